mem_stage: RTL

- Dual-lane memory-access stage sitting directly upstream of the write-back stage.
- Takes both lanes' ALU results and control from the execute pipe register.
- Performs loads and stores through a single shared data-memory port with a ready handshake, serialising lane 1 before lane 2 and stalling upstream while accesses are outstanding.
- Registers aluResult, loaded data, destination register, MemtoReg and do_writeback per lane into the MEM/WB pipe register.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_wb_lane_reg.sv | 30 +++
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-lane memory-access stage: widths, FSM
// state encoding and the per-lane MEM/WB pipe-register bundle.
package mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int REG_BITS   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] data_input;
        logic [REG_BITS-1:0]   write_register;
        logic                  mem_to_reg;
        logic                  do_writeback;
    } mem_wb_lane_t;

    // Sub-word accesses are not supported, so the byte offset is dropped.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_lane_reg.sv
// One lane of the MEM/WB pipe register; loads the lane bundle every cycle,
// or an all-zero bubble when bubble is high.
module mem_wb_lane_reg
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  mem_wb_lane_t lane_in,
    output mem_wb_lane_t lane_q
);

    mem_wb_lane_t lane_d;

    always_comb begin
        lane_d = lane_in;
        if (bubble) begin
            lane_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Dual-lane memory-access stage: serialises lane 1 then lane 2 through one
// shared data-memory port and feeds the MEM/WB pipe register.
module mem_stage
    import mem_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] aluResult1,
    input  logic [DATA_WIDTH-1:0] aluResult2,
    input  logic [DATA_WIDTH-1:0] storeData1,
    input  logic [DATA_WIDTH-1:0] storeData2,
    input  logic [REG_BITS-1:0]   writeRegister1,
    input  logic [REG_BITS-1:0]   writeRegister2,
    input  logic                  MemRead1,
    input  logic                  MemRead2,
    input  logic                  MemWrite1,
    input  logic                  MemWrite2,
    input  logic                  MemtoReg1,
    input  logic                  MemtoReg2,
    input  logic                  do_writeback1,
    input  logic                  do_writeback2,
    input  logic                  valid1,
    input  logic                  valid2,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ready,
    output logic [DATA_WIDTH-1:0] aluResult1_PR,
    output logic [DATA_WIDTH-1:0] aluResult2_PR,
    output logic [DATA_WIDTH-1:0] Data_input1_PR,
    output logic [DATA_WIDTH-1:0] Data_input2_PR,
    output logic [REG_BITS-1:0]   writeRegister1_PR,
    output logic [REG_BITS-1:0]   writeRegister2_PR,
    output logic                  MemtoReg1_PR,
    output logic                  MemtoReg2_PR,
    output logic                  do_writeback1_PR,
    output logic                  do_writeback2_PR,
    output mem_state_e            state_dbg
);

    // Memory handshake: dmem_req, dmem_we, dmem_addr and dmem_wdata stay
    // stable from the first request cycle until the cycle dmem_ready is high;
    // that cycle completes the access and dmem_rdata is sampled in it.
    // dmem_ready without dmem_req is ignored.

    mem_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [DATA_WIDTH-1:0] buf2_q, buf2_d;
    logic                  need1, need2;
    mem_wb_lane_t          lane1_in, lane2_in;
    mem_wb_lane_t          lane1_q, lane2_q;

    assign need1     = valid1 & (MemRead1 | MemWrite1);
    assign need2     = valid2 & (MemRead2 | MemWrite2);
    assign state_dbg = state_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (need1) begin
                    state_d = ACC1;
                end else if (need2) begin
                    state_d = ACC2;
                end
            end
            ACC1: begin
                if (dmem_ready) begin
                    state_d = need2 ? ACC2 : DONE;
                end
            end
            ACC2: begin
                if (dmem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state_q)
            IDLE: stall = need1 | need2;
            ACC1: begin
                stall      = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = MemWrite1;
                dmem_addr  = word_align(aluResult1[ADDR_WIDTH-1:0]);
                dmem_wdata = storeData1;
            end
            ACC2: begin
                stall      = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = MemWrite2;
                dmem_addr  = word_align(aluResult2[ADDR_WIDTH-1:0]);
                dmem_wdata = storeData2;
            end
            default: ;
        endcase
    end

    // A store also clears its buffer so no stale load data reaches write-back.
    always_comb begin
        buf1_d = buf1_q;
        buf2_d = buf2_q;
        if (state_q == ACC1 && dmem_ready) begin
            buf1_d = MemWrite1 ? '0 : dmem_rdata;
        end
        if (state_q == ACC2 && dmem_ready) begin
            buf2_d = MemWrite2 ? '0 : dmem_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            buf1_q <= '0;
            buf2_q <= '0;
        end else begin
            buf1_q <= buf1_d;
            buf2_q <= buf2_d;
        end
    end

    always_comb begin
        lane1_in.alu_result     = aluResult1;
        lane1_in.data_input     = (state_q == DONE && need1) ? buf1_q : '0;
        lane1_in.write_register = writeRegister1;
        lane1_in.mem_to_reg     = MemtoReg1;
        lane1_in.do_writeback   = do_writeback1 & valid1;
        lane2_in.alu_result     = aluResult2;
        lane2_in.data_input     = (state_q == DONE && need2) ? buf2_q : '0;
        lane2_in.write_register = writeRegister2;
        lane2_in.mem_to_reg     = MemtoReg2;
        lane2_in.do_writeback   = do_writeback2 & valid2;
    end

    // The pipe register takes a bubble exactly while upstream is stalled.
    mem_wb_lane_reg u_lane1 (
        .clk     (CLK),
        .rst     (RESET),
        .bubble  (stall),
        .lane_in (lane1_in),
        .lane_q  (lane1_q)
    );

    mem_wb_lane_reg u_lane2 (
        .clk     (CLK),
        .rst     (RESET),
        .bubble  (stall),
        .lane_in (lane2_in),
        .lane_q  (lane2_q)
    );

    assign aluResult1_PR     = lane1_q.alu_result;
    assign Data_input1_PR    = lane1_q.data_input;
    assign writeRegister1_PR = lane1_q.write_register;
    assign MemtoReg1_PR      = lane1_q.mem_to_reg;
    assign do_writeback1_PR  = lane1_q.do_writeback;
    assign aluResult2_PR     = lane2_q.alu_result;
    assign Data_input2_PR    = lane2_q.data_input;
    assign writeRegister2_PR = lane2_q.write_register;
    assign MemtoReg2_PR      = lane2_q.mem_to_reg;
    assign do_writeback2_PR  = lane2_q.do_writeback;

endmodule
